// File: rtl/dma_pkg.sv
// Shared field layout, opcode/mode codes, sequencer state encoding and
// instruction classification helpers for the instruction sequencer.
package dma_pkg;

    // Instruction field bit positions
    localparam int OP_HI   = 25;
    localparam int OP_LO   = 24;
    localparam int MODE_HI = 23;
    localparam int MODE_LO = 22;
    localparam int SRC_HI  = 21;
    localparam int SRC_LO  = 14;
    localparam int DST_HI  = 13;
    localparam int DST_LO  = 6;
    localparam int CNT_HI  = 5;
    localparam int CNT_LO  = 0;

    // Opcodes
    localparam logic [1:0] OP_MEMIO = 2'b00;
    localparam logic [1:0] OP_IOMEM = 2'b01;
    localparam logic [1:0] OP_IO1   = 2'b10;
    localparam logic [1:0] OP_IO2   = 2'b11;

    // Modes that request a DMA transfer
    localparam logic [1:0] MODE_DMA_A = 2'b01;
    localparam logic [1:0] MODE_DMA_B = 2'b10;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    // Memory-side opcode, transfer mode and a non-zero beat count
    function automatic logic is_dma_class(input logic [25:0] instr);
        logic [1:0] op;
        logic [1:0] mode;
        op   = instr[OP_HI:OP_LO];
        mode = instr[MODE_HI:MODE_LO];
        return ((op == OP_MEMIO) || (op == OP_IOMEM)) &&
               ((mode == MODE_DMA_A) || (mode == MODE_DMA_B)) &&
               (instr[CNT_HI:CNT_LO] != '0);
    endfunction

    // I/O-only instructions may issue while a transfer is running
    function automatic logic is_overlappable(input logic [25:0] instr);
        return (instr[OP_HI:OP_LO] == OP_IO1) || (instr[OP_HI:OP_LO] == OP_IO2);
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Per-beat address generator: latches a transfer descriptor on load and
// produces the source/destination/remaining-count stream one beat per step.
module dma_addr_gen (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [5:0] cnt,
    output logic [7:0] next_source,
    output logic [7:0] next_destination,
    output logic [5:0] updated_count,
    output logic       last
);

    logic [7:0] src_l;
    logic [7:0] dst_l;
    logic [5:0] cnt_l;
    logic [5:0] offset;
    logic [6:0] offset_inc;
    logic [7:0] step_off;

    assign offset_inc = {1'b0, offset} + 7'd1;
    assign last       = (offset_inc >= {1'b0, cnt_l});
    assign step_off   = {2'b00, offset_inc[5:0]};

    // Descriptor latch and beat advance; 8-bit adds wrap modulo 256
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            src_l            <= '0;
            dst_l            <= '0;
            cnt_l            <= '0;
            offset           <= '0;
            next_source      <= '0;
            next_destination <= '0;
            updated_count    <= '0;
        end else if (load) begin
            src_l            <= src;
            dst_l            <= dst;
            cnt_l            <= cnt;
            offset           <= '0;
            next_source      <= src;
            next_destination <= dst;
            updated_count    <= cnt - 6'd1;
        end else if (step) begin
            offset           <= offset_inc[5:0];
            next_source      <= src_l + step_off;
            next_destination <= dst_l + step_off;
            updated_count    <= updated_count - 6'd1;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: walks instruction memory, issues instructions,
// launches DMA transfers and lets I/O-only instructions overlap them.
module instruction_sequencer
    import dma_pkg::*;
#(
    parameter int IMEM_AW  = 13,
    parameter int PROG_LEN = 8191
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stall,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [25:0]        imem_data,
    output logic [25:0]        instruction,
    output logic               instr_valid,
    output logic               dma_start,
    output logic [7:0]         next_source,
    output logic [7:0]         next_destination,
    output logic [5:0]         updated_count,
    output logic               dma_active,
    output logic               dma_done,
    output logic               done
);

    localparam logic [IMEM_AW-1:0] LAST_PC = IMEM_AW'(PROG_LEN - 1);
    localparam logic [IMEM_AW-1:0] PC_ONE  = IMEM_AW'(1);

    logic [1:0]         state;
    logic [IMEM_AW-1:0] pc;
    logic               last_issued;
    logic               dma_class;
    logic               overlap;
    logic               at_last;
    logic               issue_ovl;
    logic               end_prog;
    logic               ag_load;
    logic               ag_step;
    logic               ag_last;

    assign imem_addr = pc;
    assign dma_class = is_dma_class(imem_data);
    assign overlap   = is_overlappable(imem_data);
    assign at_last   = (pc == LAST_PC);
    assign issue_ovl = (state == ST_XFER) && overlap && !last_issued;
    // pc saturates at the last word, so a flag records that it was issued
    assign end_prog  = last_issued || (issue_ovl && at_last);
    assign ag_load   = !stall && (state == ST_RUN) && dma_class;
    assign ag_step   = !stall && (state == ST_XFER) && !ag_last;

    dma_addr_gen u_addr_gen (
        .clock            (clock),
        .reset_n          (reset_n),
        .load             (ag_load),
        .step             (ag_step),
        .src              (imem_data[SRC_HI:SRC_LO]),
        .dst              (imem_data[DST_HI:DST_LO]),
        .cnt              (imem_data[CNT_HI:CNT_LO]),
        .next_source      (next_source),
        .next_destination (next_destination),
        .updated_count    (updated_count),
        .last             (ag_last)
    );

    // Sequencing FSM, program counter and issue/pulse registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            last_issued <= 1'b0;
            instruction <= '0;
            instr_valid <= 1'b0;
            dma_start   <= 1'b0;
            dma_active  <= 1'b0;
            dma_done    <= 1'b0;
            done        <= 1'b0;
        end else if (stall) begin
            instr_valid <= 1'b0;
            dma_start   <= 1'b0;
            dma_done    <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            dma_start   <= 1'b0;
            dma_done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_RUN;
                end
                ST_RUN: begin
                    instruction <= imem_data;
                    instr_valid <= 1'b1;
                    if (at_last) last_issued <= 1'b1;
                    else         pc <= pc + PC_ONE;
                    if (dma_class) begin
                        dma_start  <= 1'b1;
                        dma_active <= 1'b1;
                        state      <= ST_XFER;
                    end else if (at_last) begin
                        done  <= 1'b1;
                        state <= ST_HALT;
                    end
                end
                ST_XFER: begin
                    if (issue_ovl) begin
                        instruction <= imem_data;
                        instr_valid <= 1'b1;
                        if (at_last) last_issued <= 1'b1;
                        else         pc <= pc + PC_ONE;
                    end
                    if (ag_last) begin
                        dma_done   <= 1'b1;
                        dma_active <= 1'b0;
                        done       <= end_prog;
                        state      <= end_prog ? ST_HALT : ST_RUN;
                    end
                end
                default: begin
                    done <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: expected issues and DMA beats
// are queued when a program is loaded and popped as the DUT produces them.
module tb_instruction_sequencer;

    localparam int AW   = 13;
    localparam int PLEN = 4;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          start   = 1'b0;
    logic          stall   = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [25:0]   imem_data;
    logic [25:0]   instruction;
    logic          instr_valid;
    logic          dma_start;
    logic [7:0]    next_source;
    logic [7:0]    next_destination;
    logic [5:0]    updated_count;
    logic          dma_active;
    logic          dma_done;
    logic          done;

    logic [25:0]   mem [4];
    logic [52:0]   all_outs;

    always #5 clock = ~clock;

    assign imem_data = (imem_addr < AW'(4)) ? mem[imem_addr[1:0]] : '0;
    assign all_outs  = {instruction, instr_valid, dma_start, next_source, next_destination,
                        updated_count, dma_active, dma_done, done};

    instruction_sequencer #(.IMEM_AW(AW), .PROG_LEN(PLEN)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .stall            (stall),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .instruction      (instruction),
        .instr_valid      (instr_valid),
        .dma_start        (dma_start),
        .next_source      (next_source),
        .next_destination (next_destination),
        .updated_count    (updated_count),
        .dma_active       (dma_active),
        .dma_done         (dma_done),
        .done             (done)
    );

    // prev_chk: 0 none, 1 previous sample had instr_valid, 2 previous sample had dma_done
    typedef struct {
        logic [25:0] instr;
        logic        during;
        logic        is_dma;
        int          prev_chk;
    } exp_t;

    exp_t        exp_q[$];
    logic [21:0] beat_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] mk(input logic [1:0] op, input logic [1:0] mode,
                                       input logic [7:0] s, input logic [7:0] d,
                                       input logic [5:0] c);
        return {op, mode, s, d, c};
    endfunction

    task automatic push_instr(input logic [25:0] i, input logic during, input logic is_dma,
                              input int prev_chk);
        exp_t e;
        e.instr    = i;
        e.during   = during;
        e.is_dma   = is_dma;
        e.prev_chk = prev_chk;
        exp_q.push_back(e);
    endtask

    task automatic push_xfer(input logic [7:0] s, input logic [7:0] d, input int c);
        for (int i = 0; i < c; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = s + 8'(i);
            b = d + 8'(i);
            beat_q.push_back({a, b, 6'(c - 1 - i)});
        end
    endtask

    task automatic load(input logic [25:0] m0, input logic [25:0] m1,
                        input logic [25:0] m2, input logic [25:0] m3);
        mem[0] = m0;
        mem[1] = m1;
        mem[2] = m2;
        mem[3] = m3;
    endtask

    task automatic do_reset();
        start   = 1'b0;
        stall   = 1'b0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        exp_q.delete();
        beat_q.delete();
        check_eq("reset_outputs", all_outs, 0);
        check_eq("reset_pc", imem_addr, 0);
        reset_n = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_eq("done_within_budget", done, 1);
    endtask

    task automatic wait_dma_start(input int budget);
        int n = 0;
        while (dma_start !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_eq("dma_start_seen", dma_start, 1);
    endtask

    task automatic finish_prog();
        #1;
        check_eq("instr_queue_drained", exp_q.size(), 0);
        check_eq("beat_queue_drained", beat_q.size(), 0);
        check_eq("final_pc", imem_addr, PLEN - 1);
        check_eq("halt_no_active", dma_active, 0);
        start = 1'b0;
    endtask

    // Output monitor: pops the scoreboard when the DUT issues or beats
    logic       prev_valid  = 1'b0;
    logic       prev_done   = 1'b0;
    logic       prev_active = 1'b0;
    logic [5:0] prev_uc     = '0;

    always @(negedge clock) begin
        exp_t e;
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("instr_extra", instr_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("instr", instruction, e.instr);
                check_eq("issue_active", dma_active, e.during);
                check_eq("dma_start", dma_start, e.is_dma);
                if (e.prev_chk == 1) check_eq("back_to_back", prev_valid, 1);
                else if (e.prev_chk == 2) check_eq("issue_after_done", prev_done, 1);
            end
        end else begin
            check_eq("dma_start_no_issue", dma_start, 0);
        end
        if (dma_active && (dma_start || updated_count != prev_uc)) begin
            if (beat_q.size() == 0) check_eq("beat_extra", dma_active, 0);
            else check_eq("beat", {next_source, next_destination, updated_count},
                          beat_q.pop_front());
        end
        if (dma_done) begin
            check_eq("done_after_last", {prev_active, prev_uc, dma_active}, {1'b1, 6'd0, 1'b0});
        end
        prev_valid  = instr_valid;
        prev_done   = dma_done;
        prev_active = dma_active;
        prev_uc     = updated_count;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] m0, m1, m2, m3;
        logic        d_prev;
        int          n;

        // Plain run: no DMA-class instruction, four consecutive issues
        do_reset();
        m0 = mk(2'b10, 2'b00, 8'h11, 8'h22, 6'd1);
        m1 = mk(2'b11, 2'b01, 8'h33, 8'h44, 6'd2);
        m2 = mk(2'b00, 2'b00, 8'h55, 8'h66, 6'd5);
        m3 = mk(2'b00, 2'b00, 8'h00, 8'h00, 6'd0);
        load(m0, m1, m2, m3);
        push_instr(m0, 0, 0, 0);
        push_instr(m1, 0, 0, 1);
        push_instr(m2, 0, 0, 1);
        push_instr(m3, 0, 0, 1);
        start = 1'b1;
        wait_done(40);
        finish_prog();

        // Single transfer followed by plain instructions
        do_reset();
        m0 = mk(2'b00, 2'b01, 8'h10, 8'hC4, 6'd4);
        m1 = mk(2'b00, 2'b00, 8'hAA, 8'hBB, 6'd0);
        m2 = mk(2'b10, 2'b11, 8'h01, 8'h02, 6'd3);
        m3 = mk(2'b00, 2'b11, 8'h03, 8'h04, 6'd7);
        load(m0, m1, m2, m3);
        push_instr(m0, 1, 1, 0);
        push_xfer(8'h10, 8'hC4, 4);
        push_instr(m1, 0, 0, 2);
        push_instr(m2, 0, 0, 1);
        push_instr(m3, 0, 0, 1);
        start = 1'b1;
        wait_done(40);
        finish_prog();

        // Overlap: I/O instructions issue during beats, plain waits
        do_reset();
        m0 = mk(2'b00, 2'b10, 8'h80, 8'h90, 6'd3);
        m1 = mk(2'b10, 2'b01, 8'h01, 8'h02, 6'd3);
        m2 = mk(2'b11, 2'b10, 8'h05, 8'h06, 6'd5);
        m3 = mk(2'b00, 2'b00, 8'h07, 8'h08, 6'd9);
        load(m0, m1, m2, m3);
        push_instr(m0, 1, 1, 0);
        push_xfer(8'h80, 8'h90, 3);
        push_instr(m1, 1, 0, 1);
        push_instr(m2, 1, 0, 1);
        push_instr(m3, 0, 0, 2);
        start = 1'b1;
        wait_done(40);
        finish_prog();

        // Address wrap modulo 256
        do_reset();
        m0 = mk(2'b01, 2'b01, 8'hFE, 8'hFF, 6'd3);
        m1 = mk(2'b01, 2'b00, 8'h12, 8'h34, 6'd4);
        m2 = mk(2'b01, 2'b01, 8'h01, 8'h01, 6'd0);
        m3 = mk(2'b00, 2'b00, 8'h00, 8'h00, 6'd0);
        load(m0, m1, m2, m3);
        push_instr(m0, 1, 1, 0);
        push_xfer(8'hFE, 8'hFF, 3);
        push_instr(m1, 0, 0, 2);
        push_instr(m2, 0, 0, 1);
        push_instr(m3, 0, 0, 1);
        start = 1'b1;
        wait_done(40);
        finish_prog();

        // Stall for two edges mid-transfer
        do_reset();
        m0 = mk(2'b00, 2'b01, 8'h20, 8'h40, 6'd4);
        m1 = mk(2'b00, 2'b00, 8'h00, 8'h00, 6'd1);
        m2 = mk(2'b10, 2'b00, 8'h00, 8'h00, 6'd2);
        m3 = mk(2'b11, 2'b00, 8'h00, 8'h00, 6'd3);
        load(m0, m1, m2, m3);
        push_instr(m0, 1, 1, 0);
        push_xfer(8'h20, 8'h40, 4);
        push_instr(m1, 0, 0, 2);
        push_instr(m2, 0, 0, 1);
        push_instr(m3, 0, 0, 1);
        start = 1'b1;
        wait_dma_start(20);
        @(posedge clock);
        #1 stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("stall_count", updated_count, 2);
            check_eq("stall_src", next_source, 8'h21);
            check_eq("stall_dst", next_destination, 8'h41);
            check_eq("stall_pulses", {instr_valid, dma_start, dma_done}, 0);
            check_eq("stall_active", dma_active, 1);
        end
        stall = 1'b0;
        wait_done(40);
        finish_prog();

        // Asynchronous reset mid-transfer, then a full rerun
        do_reset();
        m0 = mk(2'b00, 2'b10, 8'h30, 8'h50, 6'd6);
        m1 = mk(2'b00, 2'b00, 8'h01, 8'h00, 6'd0);
        m2 = mk(2'b01, 2'b00, 8'h02, 8'h00, 6'd0);
        m3 = mk(2'b00, 2'b00, 8'h03, 8'h00, 6'd0);
        load(m0, m1, m2, m3);
        push_instr(m0, 1, 1, 0);
        push_xfer(8'h30, 8'h50, 6);
        start = 1'b1;
        wait_dma_start(20);
        @(posedge clock);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check_eq("async_reset_outputs", all_outs, 0);
        check_eq("async_reset_pc", imem_addr, 0);
        start = 1'b0;
        exp_q.delete();
        beat_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("no_dma_done_in_reset", dma_done, 0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("no_dma_done_after_reset", {dma_done, dma_active}, 0);
        end
        push_instr(m0, 1, 1, 0);
        push_xfer(8'h30, 8'h50, 6);
        push_instr(m1, 0, 0, 2);
        push_instr(m2, 0, 0, 1);
        push_instr(m3, 0, 0, 1);
        start = 1'b1;
        wait_done(60);
        finish_prog();

        // End of program on a transfer; start is ignored in HALT
        do_reset();
        m0 = mk(2'b10, 2'b10, 8'h01, 8'h02, 6'd1);
        m1 = mk(2'b00, 2'b00, 8'h03, 8'h04, 6'd0);
        m2 = mk(2'b11, 2'b00, 8'h05, 8'h06, 6'd2);
        m3 = mk(2'b00, 2'b01, 8'h05, 8'h06, 6'd2);
        load(m0, m1, m2, m3);
        push_instr(m0, 0, 0, 0);
        push_instr(m1, 0, 0, 1);
        push_instr(m2, 0, 0, 1);
        push_instr(m3, 1, 1, 1);
        push_xfer(8'h05, 8'h06, 2);
        start  = 1'b1;
        n      = 0;
        d_prev = 1'b0;
        while (dma_done !== 1'b1 && n < 40) begin
            d_prev = done;
            @(negedge clock);
            n++;
        end
        check_eq("end_dma_done_seen", dma_done, 1);
        check_eq("end_done_with_dma_done", done, 1);
        check_eq("end_done_low_before", d_prev, 0);
        for (int i = 0; i < 6; i++) begin
            start = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clock);
            check_eq("halt_done", done, 1);
            check_eq("halt_no_issue", instr_valid, 0);
        end
        finish_prog();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Front-end stage upstream of `processor` and `DMA`. It walks instruction memory and issues 26-bit instructions to the processor.
- It detects DMA-class transfers and generates the per-beat `next_source` / `next_destination` / `updated_count` stream that the DMA consumes.
- It lets I/O-only instructions (opcode 10/11) issue while a DMA transfer runs, and stalls everything else until the transfer finishes.
- It replaces the behavioural sequencing currently done in the system bench.

Parameters:
- IMEM_AW, 13, instruction memory address width (8192 words).
- PROG_LEN, 8191, number of valid program words; the last issued address is PROG_LEN-1.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE when high.
- stall  in  1  freezes all state and outputs for the cycle.
- imem_addr  out  IMEM_AW  instruction memory address (= pc).
- imem_data  in  26  combinational read data for imem_addr.
- instruction  out  26  instruction to processor, registered.
- instr_valid  out  1  instruction is new this cycle.
- dma_start  out  1  one-cycle pulse, issued with a DMA-class instruction.
- next_source  out  8  current beat source address.
- next_destination  out  8  current beat destination address.
- updated_count  out  6  beats remaining after the current beat.
- dma_active  out  1  a transfer is in progress.
- dma_done  out  1  one-cycle pulse after the final beat.
- done  out  1  program finished and no transfer pending.

Behaviour:
- Instruction fields:
  - [25:24] op
  - [23:22] mode
  - [21:14] src
  - [13:6] dst
  - [5:0] cnt
- DMA-class means: op in {00,01}, mode in {01,10}, and cnt>=1. Overlappable means op in {10,11}. All other instructions are plain.
- Reset (async, reset_n=0):
  - state=IDLE, pc=0.
  - instruction=0; instr_valid, dma_start, dma_active, dma_done and done all 0.
  - next_source=0, next_destination=0, updated_count=0, offset=0.
  - Reset mid-transfer aborts it; no dma_done is produced.
- stall=1: no state, pc or output register changes. Pulses (instr_valid, dma_start, dma_done) are held at 0 for the stall cycle.
- FSM states: IDLE, RUN, XFER, HALT.
- IDLE: go to RUN on start=1. No issue in this cycle.
- RUN, one issue per cycle:
  - Always: instruction<=imem_data, instr_valid<=1, pc<=pc+1.
  - If DMA-class:
    - Latch src, dst, cnt; offset<=0.
    - Also: dma_start<=1, dma_active<=1, next_source<=src, next_destination<=dst, updated_count<=cnt-1.
    - Go to XFER.
- XFER, one beat per cycle after the dma_start cycle:
  - While offset+1 < cnt_l: offset++, next_source<=src_l+offset+1, next_destination<=dst_l+offset+1, updated_count<=updated_count-1.
  - When updated_count==0 in XFER: dma_done<=1, dma_active<=0, go to RUN. So a cnt=N transfer has dma_active high exactly N cycles.
  - Same cycle, if imem_data is overlappable: issue it (instr_valid=1, pc++). Otherwise instr_valid=0 and pc holds.
  - Address arithmetic is 8-bit and wraps modulo 256 (e.g. src=0xFE, cnt=3 gives FE, FF, 00).
- Simultaneous events:
  - A plain or DMA-class instruction waiting when the final beat occurs issues on the first RUN cycle, i.e. the cycle after dma_done.
  - Back-to-back DMA-class instructions therefore have a 1-cycle gap between last beat and the next dma_start.
- End of program:
  - When pc would advance past PROG_LEN-1, pc saturates.
  - State goes to HALT once dma_active=0 (from RUN immediately; from XFER after its final beat).
  - HALT: done=1, instr_valid=0, stays until reset. start is ignored.
- Address map (memory 0-191, IO1 192-223, IO2 224-255) is not checked here. Decoding stays downstream.

Decomposition:
- Package `dma_pkg`:
  - Field slice constants (OP_HI=25 … CNT_LO=0).
  - Opcode/mode localparams (OP_MEMIO=2'b00, OP_IOMEM=2'b01, OP_IO1=2'b10, OP_IO2=2'b11).
  - State encoding.
  - Functions is_dma_class() and is_overlappable().
- Natural sub-module `dma_addr_gen`: offset counter, src/dst adders and remaining-count down-counter, with load/step/last interface. The FSM and pc stay in the top level.

Test Plan:
- Plain run: program [10_00_.., 11_01_.., 00_00_..cnt=5], start=1 → instr_valid on 3 consecutive cycles, pc 0→3, dma_start never asserted (mode 00).
- Single transfer: 00_01 src=0x10 dst=0xC4 cnt=4, followed by a plain instruction → dma_start once; next_source 10,11,12,13; next_destination C4..C7; updated_count 3,2,1,0. The following plain instruction issues the cycle after dma_done.
- Overlap: transfer cnt=3 followed by 10_xx, 11_xx, 00_00 → both I/O instructions issue during beats 2–3; the 00_00 instruction waits and issues one cycle after dma_done.
- Wrap: src=0xFE dst=0xFF cnt=3 → sources FE, FF, 00; destinations FF, 00, 01.
- Stall/reset: assert stall for 2 cycles mid-transfer → outputs frozen, beat count unchanged overall. Pull reset_n low asynchronously mid-transfer → all outputs 0 immediately, pc=0, no dma_done.
- End: PROG_LEN=4 ending in a cnt=2 transfer → done rises the cycle after the final beat and stays high; start toggling has no effect.
